// File: rtl/program_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// program_sequencer_pkg
//   Shared widths, instruction field positions, HALT opcode and the sequencer
//   state encoding. Imported by the interface, the decoder and the top level.
//   Instruction word layout: {opcode[19:16], B[15:8], A[7:0]}.
// ---------------------------------------------------------------------------
package program_sequencer_pkg;

   localparam int ADDR_W  = 4;
   localparam int DATA_W  = 8;
   localparam int OPC_W   = 4;
   localparam int INSTR_W = OPC_W + 2*DATA_W;

   localparam int OPC_MSB = 19;
   localparam int B_MSB   = 15;
   localparam int A_MSB   = 7;

   localparam logic [OPC_W-1:0]  HALT_OPC  = 4'hF;
   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   typedef enum logic [2:0] {
      ST_LOAD   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_ISSUE  = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5
   } state_t;

endpackage

// File: rtl/program_sequencer_if.sv
// ---------------------------------------------------------------------------
// program_sequencer_if
//   Instruction-memory bus and ALU valid/done handshake between the sequencer
//   (master) and the memory/ALU side (slave).
//   mem_addr/mem_we/mem_wdata : memory address, write enable, write data
//   mem_rdata                 : synchronous read data, 1-cycle latency
//   alu_valid/opcode/a/b      : operation request, held until alu_done
//   alu_done/alu_result       : completion strobe and result
// ---------------------------------------------------------------------------
interface program_sequencer_if;
   import program_sequencer_pkg::*;

   logic [ADDR_W-1:0]  mem_addr;
   logic               mem_we;
   logic [INSTR_W-1:0] mem_wdata;
   logic [INSTR_W-1:0] mem_rdata;

   logic               alu_valid;
   logic [OPC_W-1:0]   alu_opcode;
   logic [DATA_W-1:0]  alu_a;
   logic [DATA_W-1:0]  alu_b;
   logic               alu_done;
   logic [DATA_W-1:0]  alu_result;

   modport master (
      output mem_addr, mem_we, mem_wdata, alu_valid, alu_opcode, alu_a, alu_b,
      input  mem_rdata, alu_done, alu_result
   );

   modport slave (
      input  mem_addr, mem_we, mem_wdata, alu_valid, alu_opcode, alu_a, alu_b,
      output mem_rdata, alu_done, alu_result
   );

endinterface

// File: rtl/program_sequencer_instr_decoder.sv
// ---------------------------------------------------------------------------
// program_sequencer_instr_decoder
//   Purely combinational split of an instruction word into its fields plus a
//   HALT flag. Shared with the disassembler/trace monitor.
//   i_instr   : INSTR_W instruction word
//   o_opcode  : opcode field
//   o_b, o_a  : operand fields
//   o_is_halt : opcode equals HALT_OPC
// ---------------------------------------------------------------------------
module program_sequencer_instr_decoder
   import program_sequencer_pkg::*;
(
   input  logic [INSTR_W-1:0] i_instr,
   output logic [OPC_W-1:0]   o_opcode,
   output logic [DATA_W-1:0]  o_b,
   output logic [DATA_W-1:0]  o_a,
   output logic               o_is_halt
);

   assign o_opcode  = i_instr[OPC_MSB -: OPC_W];
   assign o_b       = i_instr[B_MSB -: DATA_W];
   assign o_a       = i_instr[A_MSB -: DATA_W];
   assign o_is_halt = (o_opcode == HALT_OPC);

endmodule

// File: rtl/program_sequencer.sv
// ---------------------------------------------------------------------------
// program_sequencer
//   Fetch/execute controller between a 16-entry instruction memory and an
//   8-bit ALU. LOAD mode passes user writes through to memory; RUN mode walks
//   pc from 0, issues each decoded instruction to the ALU and publishes the
//   result, stopping on HALT or after the last address.
//   clk, reset        : clock, asynchronous active-low reset
//   op                : 0 = LOAD, 1 = RUN (dropping to 0 aborts a run)
//   write_memory, user_address, in_data : user write port (LOAD only)
//   bus               : memory bus + ALU handshake (master side)
//   result_out        : last committed result
//   result_valid      : one-cycle pulse per committed result
//   pc, busy, halted  : program counter and status
// ---------------------------------------------------------------------------
module program_sequencer
   import program_sequencer_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                op,
   input  logic                write_memory,
   input  logic [ADDR_W-1:0]   user_address,
   input  logic [INSTR_W-1:0]  in_data,
   program_sequencer_if.master bus,
   output logic [DATA_W-1:0]   result_out,
   output logic                result_valid,
   output logic [ADDR_W-1:0]   pc,
   output logic                busy,
   output logic                halted
);

   state_t             r_state;
   state_t             w_next;
   logic [ADDR_W-1:0]  r_pc;
   logic [OPC_W-1:0]   r_ir_opc;
   logic [DATA_W-1:0]  r_ir_b;
   logic [DATA_W-1:0]  r_ir_a;
   logic [DATA_W-1:0]  r_alu_res;
   logic [DATA_W-1:0]  r_result;

   logic [OPC_W-1:0]   w_dec_opc;
   logic [DATA_W-1:0]  w_dec_b;
   logic [DATA_W-1:0]  w_dec_a;
   logic               w_dec_halt;

   // Decodes the memory word arriving this cycle so DECODE can branch on HALT
   // without waiting for the instruction register.
   program_sequencer_instr_decoder u_decoder (
      .i_instr   (bus.mem_rdata),
      .o_opcode  (w_dec_opc),
      .o_b       (w_dec_b),
      .o_a       (w_dec_a),
      .o_is_halt (w_dec_halt)
   );

   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge values of the others.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= ST_LOAD;
      else        r_state <= w_next;
   end

   // op=0 in any run state aborts straight back to LOAD.
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_LOAD:   if (op) w_next = ST_FETCH;
         ST_FETCH:  w_next = op ? ST_DECODE : ST_LOAD;
         ST_DECODE: begin
            if (!op)            w_next = ST_LOAD;
            else if (w_dec_halt) w_next = ST_HALT;
            else                w_next = ST_ISSUE;
         end
         ST_ISSUE: begin
            if (!op)              w_next = ST_LOAD;
            else if (bus.alu_done) w_next = ST_WB;
         end
         ST_WB: begin
            if (!op)                    w_next = ST_LOAD;
            else if (r_pc == LAST_ADDR) w_next = ST_HALT;
            else                        w_next = ST_FETCH;
         end
         ST_HALT:   if (!op) w_next = ST_LOAD;
         default:   w_next = ST_LOAD;
      endcase
   end

   // NOTE: every output gets a default before the case so no path leaves one
   // unassigned and no latch is inferred.
   always_comb begin
      bus.mem_addr   = r_pc;
      bus.mem_we     = 1'b0;
      bus.mem_wdata  = '0;
      bus.alu_valid  = 1'b0;
      bus.alu_opcode = '0;
      bus.alu_a      = '0;
      bus.alu_b      = '0;
      result_valid   = 1'b0;
      busy           = 1'b0;
      halted         = 1'b0;
      unique case (r_state)
         ST_LOAD: begin
            // Pass-through is gated by reset so all outputs read 0 while held.
            if (reset) begin
               bus.mem_addr  = user_address;
               bus.mem_we    = write_memory;
               bus.mem_wdata = in_data;
            end
         end
         ST_FETCH, ST_DECODE: busy = 1'b1;
         ST_ISSUE: begin
            busy           = 1'b1;
            bus.alu_valid  = 1'b1;
            bus.alu_opcode = r_ir_opc;
            bus.alu_a      = r_ir_a;
            bus.alu_b      = r_ir_b;
         end
         ST_WB: begin
            busy         = 1'b1;
            // An abort sampled in WB suppresses the commit.
            result_valid = op;
         end
         ST_HALT: halted = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pc      <= '0;
         r_ir_opc  <= '0;
         r_ir_b    <= '0;
         r_ir_a    <= '0;
         r_alu_res <= '0;
         r_result  <= '0;
      end else begin
         case (r_state)
            ST_LOAD:   if (op) r_pc <= '0;
            ST_DECODE: begin
               r_ir_opc <= w_dec_opc;
               r_ir_b   <= w_dec_b;
               r_ir_a   <= w_dec_a;
            end
            ST_ISSUE:  if (op && bus.alu_done) r_alu_res <= bus.alu_result;
            ST_WB: begin
               if (op) begin
                  r_result <= r_alu_res;
                  // Last address halts in place rather than wrapping to 0.
                  if (r_pc != LAST_ADDR) r_pc <= r_pc + ADDR_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign result_out = r_result;
   assign pc         = r_pc;

endmodule

// File: tb/tb_program_sequencer.sv
module tb_program_sequencer;
   import program_sequencer_pkg::*;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [OPC_W-1:0]  opc;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [DATA_W-1:0] res;
   } exp_t;

   localparam logic [INSTR_W-1:0] HALT_W = 20'hF0000;

   logic               clk = 1'b0;
   logic               reset;
   logic               op;
   logic               write_memory;
   logic [ADDR_W-1:0]  user_address;
   logic [INSTR_W-1:0] in_data;
   logic [DATA_W-1:0]  result_out;
   logic               result_valid;
   logic [ADDR_W-1:0]  pc;
   logic               busy;
   logic               halted;

   program_sequencer_if bus ();

   program_sequencer dut (
      .clk          (clk),
      .reset        (reset),
      .op           (op),
      .write_memory (write_memory),
      .user_address (user_address),
      .in_data      (in_data),
      .bus          (bus),
      .result_out   (result_out),
      .result_valid (result_valid),
      .pc           (pc),
      .busy         (busy),
      .halted       (halted)
   );

   always #5 clk = ~clk;

   // Instruction memory: synchronous read, 1-cycle latency.
   logic [INSTR_W-1:0] mem [2**ADDR_W];
   always @(posedge clk) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= mem[bus.mem_addr];
   end

   function automatic logic [DATA_W-1:0] alu_fn(input logic [OPC_W-1:0] opc,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
      case (opc)
         4'd0:    return a + b;
         4'd1:    return b - a;
         4'd2:    return a & b;
         4'd3:    return a | b;
         default: return a ^ b;
      endcase
   endfunction

   // ALU: done after alu_delay wait cycles (0 = same cycle as valid).
   int alu_delay = 0;
   int alu_cnt;
   always @(posedge clk or negedge reset) begin
      if (!reset) alu_cnt <= 0;
      else        alu_cnt <= (bus.alu_valid && !bus.alu_done) ? alu_cnt + 1 : 0;
   end
   always_comb begin
      bus.alu_done   = bus.alu_valid && (alu_cnt >= alu_delay);
      bus.alu_result = alu_fn(bus.alu_opcode, bus.alu_a, bus.alu_b);
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [INSTR_W-1:0] shadow [2**ADDR_W];
   exp_t               exp_q [$];
   exp_t               head;
   logic [ADDR_W-1:0]  exp_halt_pc;
   logic [DATA_W-1:0]  model_ro;
   logic [DATA_W-1:0]  pend_val;
   bit                 pend;
   int                 pulses;
   int                 busy_cycles;
   int                 cur_len;
   logic [DATA_W-1:0]  a_log [$];
   logic [DATA_W-1:0]  b_log [$];
   logic [DATA_W-1:0]  res_log [$];
   int                 len_log [$];
   logic               prev_valid;
   logic               prev_halted;
   logic [OPC_W-1:0]   prev_opc;
   logic [DATA_W-1:0]  prev_a;
   logic [DATA_W-1:0]  prev_b;

   // Expected execution trace: instructions from address 0 up to the first
   // HALT word, or all of memory when there is none.
   task automatic start_run();
      exp_t e;
      exp_q.delete();
      a_log.delete(); b_log.delete(); res_log.delete(); len_log.delete();
      pulses = 0;
      busy_cycles = 0;
      exp_halt_pc = ADDR_W'(2**ADDR_W - 1);
      for (int i = 0; i < 2**ADDR_W; i++) begin
         if (shadow[i][19:16] == 4'hF) begin
            exp_halt_pc = ADDR_W'(i);
            break;
         end
         e.addr = ADDR_W'(i);
         e.opc  = shadow[i][19:16];
         e.b    = shadow[i][15:8];
         e.a    = shadow[i][7:0];
         e.res  = alu_fn(e.opc, e.a, e.b);
         exp_q.push_back(e);
      end
      op = 1'b1;
   endtask

   // Per-cycle compare against the model.
   initial begin : compare
      forever begin
         @(negedge clk);
         if (!reset) begin
            exp_q.delete();
            pend = 1'b0;
            model_ro = '0;
            prev_valid = 1'b0;
            prev_halted = 1'b0;
            cur_len = 0;
         end else begin
            if (busy || halted) check("mem_we_in_run", 32'(bus.mem_we), 0);
            check("busy_and_halted", 32'(busy && halted), 0);
            if (pend) begin
               model_ro = pend_val;
               pend = 1'b0;
               res_log.push_back(result_out);
            end
            check("result_out", 32'(result_out), 32'(model_ro));
            if (busy) busy_cycles++;
            if (bus.alu_valid) begin
               cur_len++;
               check("issue_expected", 32'(exp_q.size() != 0), 1);
               if (exp_q.size() != 0) begin
                  head = exp_q[0];
                  check("issue_pc", 32'(pc), 32'(head.addr));
                  if (!prev_valid) begin
                     check("issue_opcode", 32'(bus.alu_opcode), 32'(head.opc));
                     check("issue_a", 32'(bus.alu_a), 32'(head.a));
                     check("issue_b", 32'(bus.alu_b), 32'(head.b));
                     a_log.push_back(bus.alu_a);
                     b_log.push_back(bus.alu_b);
                  end else begin
                     check("hold_opcode", 32'(bus.alu_opcode), 32'(prev_opc));
                     check("hold_a", 32'(bus.alu_a), 32'(prev_a));
                     check("hold_b", 32'(bus.alu_b), 32'(prev_b));
                  end
               end
            end else if (prev_valid) begin
               len_log.push_back(cur_len);
               cur_len = 0;
            end
            if (result_valid) begin
               check("result_expected", 32'(exp_q.size() != 0), 1);
               if (exp_q.size() != 0) begin
                  head = exp_q.pop_front();
                  check("wb_pc", 32'(pc), 32'(head.addr));
                  pend_val = head.res;
                  pend = 1'b1;
                  pulses++;
               end
            end
            if (halted && !prev_halted) begin
               check("halt_pc", 32'(pc), 32'(exp_halt_pc));
               check("halt_all_issued", exp_q.size(), 0);
            end
            prev_valid  = bus.alu_valid;
            prev_halted = halted;
            prev_opc    = bus.alu_opcode;
            prev_a      = bus.alu_a;
            prev_b      = bus.alu_b;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input int addr, input logic [INSTR_W-1:0] data);
      user_address = ADDR_W'(addr);
      in_data      = data;
      write_memory = 1'b1;
      #1;
      check("load_mem_we", 32'(bus.mem_we), 1);
      check("load_mem_addr", 32'(bus.mem_addr), 32'(addr));
      check("load_mem_wdata", 32'(bus.mem_wdata), 32'(data));
      tick();
      write_memory = 1'b0;
      shadow[addr] = data;
   endtask

   task automatic wait_halt(input int budget, input string name);
      int n = 0;
      while (!halted && n < budget) begin
         tick();
         n++;
      end
      check(name, 32'(halted), 1);
      tick();
   endtask

   task automatic end_run();
      op = 1'b0;
      tick();
      check("back_to_load_halted", 32'(halted), 0);
      check("back_to_load_busy", 32'(busy), 0);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_mem_addr"}, 32'(bus.mem_addr), 0);
      check({tag, "_mem_we"}, 32'(bus.mem_we), 0);
      check({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 0);
      check({tag, "_alu_valid"}, 32'(bus.alu_valid), 0);
      check({tag, "_alu_opcode"}, 32'(bus.alu_opcode), 0);
      check({tag, "_alu_a"}, 32'(bus.alu_a), 0);
      check({tag, "_alu_b"}, 32'(bus.alu_b), 0);
      check({tag, "_result_out"}, 32'(result_out), 0);
      check({tag, "_result_valid"}, 32'(result_valid), 0);
      check({tag, "_pc"}, 32'(pc), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_halted"}, 32'(halted), 0);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- test sequence ----------------
   initial begin : stim
      int n;
      int plen;
      reset = 1'b0; op = 1'b0; write_memory = 1'b0;
      user_address = 4'd3; in_data = 20'h5A5A5;
      #12;
      check_outputs_zero("rst");
      @(posedge clk); #1 reset = 1'b1;
      user_address = '0; in_data = '0;
      tick();
      for (int i = 0; i < 2**ADDR_W; i++) write_word(i, HALT_W);

      // Load then run: add (B=0x01, A=0x02), then sub (B=0x03, A=0x00), HALT.
      write_word(0, 20'h00102);
      write_word(1, 20'h10300);
      alu_delay = 0;
      start_run();
      wait_halt(100, "t1_halt");
      check("t1_pc", 32'(pc), 2);
      check("t1_pulses", pulses, 2);
      check("t1_busy_cycles", busy_cycles, 10);
      check("t1_issue_count", a_log.size(), 2);
      check("t1_result_count", res_log.size(), 2);
      check("t1_a0", 32'(a_log[0]), 32'h02);
      check("t1_b0", 32'(b_log[0]), 32'h01);
      check("t1_res0", 32'(res_log[0]), 32'h03);
      check("t1_a1", 32'(a_log[1]), 32'h00);
      check("t1_b1", 32'(b_log[1]), 32'h03);
      check("t1_res1", 32'(res_log[1]), 32'h03);
      // HALT holds while op stays 1.
      repeat (3) tick();
      check("t1_halt_hold", 32'(halted), 1);
      end_run();

      // Write strobes during RUN must not reach memory.
      write_word(5, 20'h2A5A5);
      start_run();
      tick(); tick();
      check("t2_busy_at_strobe", 32'(busy), 1);
      user_address = 4'd5; in_data = 20'h12345; write_memory = 1'b1;
      repeat (4) tick();
      write_memory = 1'b0;
      wait_halt(100, "t2_halt");
      end_run();
      user_address = 4'd5;
      tick();
      check("t2_addr5_model", 32'(bus.mem_rdata), 32'(shadow[5]));
      check("t2_addr5_literal", 32'(bus.mem_rdata), 32'h2A5A5);

      // Wait-state ALU: B=0x40, A=0x10, sub -> 0x30, done after 3 waits.
      write_word(0, 20'h14010);
      write_word(1, HALT_W);
      alu_delay = 3;
      start_run();
      wait_halt(100, "t3_halt");
      check("t3_pulses", pulses, 1);
      check("t3_valid_len", len_log[0], 4);
      check("t3_result", 32'(res_log[0]), 32'h30);
      check("t3_busy_cycles", busy_cycles, 9);
      check("t3_pc", 32'(pc), 1);
      end_run();

      // End of memory: 16 non-HALT words, halt at 15 without wrapping.
      for (int i = 0; i < 2**ADDR_W; i++)
         write_word(i, {OPC_W'($urandom_range(0, 14)), DATA_W'($urandom), DATA_W'($urandom)});
      alu_delay = 1;
      start_run();
      wait_halt(400, "t4_halt");
      check("t4_pulses", pulses, 16);
      check("t4_pc", 32'(pc), 15);
      repeat (4) tick();
      check("t4_pc_no_wrap", 32'(pc), 15);
      check("t4_still_halted", 32'(halted), 1);
      end_run();

      // Abort during ISSUE of instruction 1.
      write_word(0, 20'h00305);
      write_word(1, 20'h10907);
      write_word(2, 20'h2FF0F);
      write_word(3, HALT_W);
      alu_delay = 4;
      start_run();
      n = 0;
      while (!(bus.alu_valid && pc == 4'd1) && n < 100) begin
         tick();
         n++;
      end
      check("t5_reached_issue1", 32'(bus.alu_valid && pc == 4'd1), 1);
      op = 1'b0;
      tick();
      exp_q.delete();
      check("t5_alu_valid", 32'(bus.alu_valid), 0);
      check("t5_busy", 32'(busy), 0);
      check("t5_halted", 32'(halted), 0);
      check("t5_result_valid", 32'(result_valid), 0);
      check("t5_pc_kept", 32'(pc), 1);
      check("t5_result_kept", 32'(result_out), 32'h08);
      repeat (3) tick();
      check("t5_pulses", pulses, 1);

      // Randomised programs with random ALU wait states.
      for (int r = 0; r < 8; r++) begin
         plen = $urandom_range(1, 6);
         for (int i = 0; i < plen; i++)
            write_word(i, {OPC_W'($urandom_range(0, 14)), DATA_W'($urandom), DATA_W'($urandom)});
         write_word(plen, HALT_W);
         alu_delay = $urandom_range(0, 3);
         start_run();
         wait_halt(200, "rand_halt");
         check("rand_pulses", pulses, plen);
         check("rand_pc", 32'(pc), 32'(plen));
         end_run();
      end

      // Asynchronous reset in the middle of WB.
      write_word(0, 20'h00102);
      write_word(1, 20'h10300);
      write_word(2, HALT_W);
      alu_delay = 0;
      user_address = 4'd7; in_data = 20'hABCDE;
      start_run();
      n = 0;
      while (!result_valid && n < 50) begin
         tick();
         n++;
      end
      check("t7_reached_wb", 32'(result_valid), 1);
      #2 reset = 1'b0;
      op = 1'b0;
      #1;
      check_outputs_zero("t7");
      @(posedge clk); #1 reset = 1'b1;
      tick();
      check("t7_load_busy", 32'(busy), 0);
      check("t7_load_halted", 32'(halted), 0);
      check("t7_load_mem_addr", 32'(bus.mem_addr), 7);
      check("t7_load_pc", 32'(pc), 0);
      check("t7_load_result", 32'(result_out), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
